mem_rsp: RTL and testbench
==========================

MEM_RSP -- requirements
Module: mem_rsp

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning request/response tag width.
REQ-002 SHALL have parameter MCN_W, default 58, meaning memory cache-line number width.
REQ-003 SHALL have parameter DATA_W, default 512, meaning response line width.
REQ-004 SHALL have parameter DEPTH, default 8, meaning outstanding-request queue entries (power of two).
REQ-005 SHALL have parameter LAT, default 4, meaning minimum accept-to-response cycles (1..15).
REQ-006 SHALL have parameter TBL_AW, default 8, meaning backing-table address width.
REQ-007 clock  in  1  single clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset; state cleared while reset==0.
REQ-009 mem_req_i_valid / mem_req_i_ready  in / out  1 each  request handshake.
REQ-010 mem_req_i_bits_idx / mem_req_i_bits_mcn  in  IDX_W / MCN_W  request tag, line number.
REQ-011 mem_res_o_valid / mem_res_o_ready  out / in  1 each  response handshake.
REQ-012 mem_res_o_bits_idx / mem_res_o_bits_data  out  IDX_W / DATA_W  echoed tag, line data.
REQ-013 ld_valid / ld_addr / ld_data  in  1 / TBL_AW / DATA_W  backing-table write port, no handshake.
REQ-014 busy_o  out  1  high while any request is queued.

Function
REQ-015 Request accepted on cycle with mem_req_i_valid & mem_req_i_ready; mem_req_i_ready SHALL equal ~full (no enqueue while full, even with same-cycle dequeue).
REQ-016 Accepted request SHALL be pushed into an in-order queue entry {idx, addr=mcn[TBL_AW-1:0], oor=|mcn[MCN_W-1:TBL_AW], cnt=LAT-1}.
REQ-017 Each valid entry's cnt SHALL decrement by 1 per cycle, saturating at 0.
REQ-018 mem_res_o_valid SHALL be high iff queue non-empty and head cnt==0; minimum latency accept-edge to valid = LAT cycles.
REQ-019 Response bits_idx SHALL be head idx; bits_data SHALL be table[addr] read combinationally, or all-zero when oor set.
REQ-020 Once valid, response SHALL hold valid and all bits stable until mem_res_o_ready; head pops on valid & ready.
REQ-021 Responses SHALL be returned strictly in acceptance order; no reordering, no drop.
REQ-022 ld_valid SHALL write table[ld_addr]=ld_data at the edge; same-cycle response from that address returns pre-write data.
REQ-023 Pointers SHALL wrap modulo DEPTH; full/empty distinguished by extra pointer bit.
REQ-024 Simultaneous push and pop when neither full nor empty SHALL keep occupancy unchanged.
REQ-025 busy_o SHALL equal ~empty.

Reset
REQ-026 On reset==0: queue empty, pointers 0, mem_req_i_ready=0 during reset then 1, mem_res_o_valid=0, busy_o=0.
REQ-027 Backing table SHALL NOT be cleared by reset; in-flight requests at reset assertion SHALL be discarded without response.
REQ-028 First request accepted on first rising edge after reset==1.

Structure
REQ-029 Package mem_rsp_pkg SHALL hold default widths and the queue entry struct type.
REQ-030 Backing table SHALL be sub-module mem_rsp_tbl (one write port, one async read port); queue and counters live in mem_rsp.

Verification
REQ-031 Load table[0x12]=0xA5..A5; request idx=3 mcn=0x12, res_ready=1 -> valid exactly 4 cycles later, idx=3, data=0xA5..A5.
REQ-032 Eight back-to-back requests idx 0..7, res_ready=0 -> ready low after 8th; raise res_ready -> responses idx 0..7 in order, one per cycle.
REQ-033 Request mcn=0x100 (TBL_AW=8) -> response data all-zero, idx echoed.
REQ-034 res_ready toggled randomly for 1000 requests -> no change of bits while valid & ~ready; tag sequence matches acceptance order.
REQ-035 Assert reset with 3 queued requests -> valid=0, busy_o=0 immediately; no stale response after release; table contents retained.
REQ-036 ld_valid to addr 0x05 same cycle as response from 0x05 -> old data returned; next request to 0x05 returns new data.

Source files
------------

// File: rtl/mem_rsp_pkg.sv
// Shared defaults and queue-entry layout for the mem_rsp response engine.
package mem_rsp_pkg;

   localparam int DEF_IDX_W  = 6;
   localparam int DEF_MCN_W  = 58;
   localparam int DEF_DATA_W = 512;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_LAT    = 4;
   localparam int DEF_TBL_AW = 8;
   localparam int CNT_W      = 4;

   // Queue entry at the default widths; mem_rsp builds the same layout from its own parameters.
   typedef struct packed {
      logic [DEF_IDX_W-1:0]  idx;
      logic [DEF_TBL_AW-1:0] addr;
      logic                  oor;
      logic [CNT_W-1:0]      cnt;
   } entry_t;

endpackage

// File: rtl/mem_rsp_tbl.sv
// Backing line table: one synchronous write port, one combinational read port, never cleared.
module mem_rsp_tbl #(
   parameter int AW = 8,
   parameter int DW = 512
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_rsp.sv
// In-order memory response engine: queues tagged requests, releases each after a fixed
// countdown and returns the table line (or zero for out-of-range lines) with the echoed tag.
module mem_rsp
   import mem_rsp_pkg::*;
#(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int MCN_W  = DEF_MCN_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int LAT    = DEF_LAT,
   parameter int TBL_AW = DEF_TBL_AW
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_req_i_valid,
   output logic              mem_req_i_ready,
   input  logic [IDX_W-1:0]  mem_req_i_bits_idx,
   input  logic [MCN_W-1:0]  mem_req_i_bits_mcn,
   output logic              mem_res_o_valid,
   input  logic              mem_res_o_ready,
   output logic [IDX_W-1:0]  mem_res_o_bits_idx,
   output logic [DATA_W-1:0] mem_res_o_bits_data,
   input  logic              ld_valid,
   input  logic [TBL_AW-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              busy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [TBL_AW-1:0] addr;
      logic              oor;
      logic [CNT_W-1:0]  cnt;
   } q_entry_t;

   q_entry_t          queue [DEPTH];
   q_entry_t          head;
   q_entry_t          new_entry;
   logic [PW:0]       wr_ptr;
   logic [PW:0]       rd_ptr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              hold_vld;
   logic [DATA_W-1:0] hold_data;
   logic [DATA_W-1:0] tbl_rdata;
   logic [DATA_W-1:0] live_data;

   assign head  = queue[rd_ptr[PW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   // Ready is held low while reset is asserted, then reflects only queue fullness.
   assign mem_req_i_ready = reset & ~full;
   assign push            = mem_req_i_valid & mem_req_i_ready;
   assign mem_res_o_valid = ~empty & (head.cnt == '0);
   assign pop             = mem_res_o_valid & mem_res_o_ready;
   assign busy_o          = ~empty;

   assign new_entry = '{idx:  mem_req_i_bits_idx,
                        addr: mem_req_i_bits_mcn[TBL_AW-1:0],
                        oor:  |mem_req_i_bits_mcn[MCN_W-1:TBL_AW],
                        cnt:  CNT_INIT};

   assign live_data           = head.oor ? '0 : tbl_rdata;
   assign mem_res_o_bits_idx  = head.idx;
   // A stalled response keeps the line it first presented, even if the table is rewritten meanwhile.
   assign mem_res_o_bits_data = hold_vld ? hold_data : live_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         hold_vld <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (pop) begin
            hold_vld <= 1'b0;
         end else if (mem_res_o_valid) begin
            hold_vld <= 1'b1;
         end
      end
   end

   // Entry payloads need no reset: the pointers alone decide which entries are live.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (queue[i].cnt != '0) begin
            queue[i].cnt <= queue[i].cnt - 1'b1;
         end
      end
      if (push) begin
         queue[wr_ptr[PW-1:0]] <= new_entry;
      end
      if (mem_res_o_valid && !hold_vld) begin
         hold_data <= live_data;
      end
   end

   mem_rsp_tbl #(
      .AW (TBL_AW),
      .DW (DATA_W)
   ) u_tbl (
      .clock   (clock),
      .wr_en   (ld_valid),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_addr (head.addr),
      .rd_data (tbl_rdata)
   );

endmodule

// File: tb/tb_mem_rsp.sv
// Directed and table-driven bench for mem_rsp at its default parameters.
module tb_mem_rsp;

   typedef logic [511:0] line_t;

   typedef struct {
      logic [5:0]  idx;
      logic [57:0] mcn;
      line_t       exp_data;
      int          exp_lat;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req_i_valid;
   logic        mem_req_i_ready;
   logic [5:0]  mem_req_i_bits_idx;
   logic [57:0] mem_req_i_bits_mcn;
   logic        mem_res_o_valid;
   logic        mem_res_o_ready;
   logic [5:0]  mem_res_o_bits_idx;
   line_t       mem_res_o_bits_data;
   logic        ld_valid;
   logic [7:0]  ld_addr;
   line_t       ld_data;
   logic        busy_o;

   int    checks   = 0;
   int    failures = 0;
   line_t tbl_model [256];

   always #5 clock = ~clock;

   mem_rsp dut (
      .clock               (clock),
      .reset               (reset),
      .mem_req_i_valid     (mem_req_i_valid),
      .mem_req_i_ready     (mem_req_i_ready),
      .mem_req_i_bits_idx  (mem_req_i_bits_idx),
      .mem_req_i_bits_mcn  (mem_req_i_bits_mcn),
      .mem_res_o_valid     (mem_res_o_valid),
      .mem_res_o_ready     (mem_res_o_ready),
      .mem_res_o_bits_idx  (mem_res_o_bits_idx),
      .mem_res_o_bits_data (mem_res_o_bits_data),
      .ld_valid            (ld_valid),
      .ld_addr             (ld_addr),
      .ld_data             (ld_data),
      .busy_o              (busy_o)
   );

   function automatic line_t pat(input logic [31:0] w);
      return {16{w}};
   endfunction

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check_output(input string name, input line_t act, input line_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [7:0] addr, input line_t data);
      ld_valid = 1'b1;
      ld_addr  = addr;
      ld_data  = data;
      tbl_model[addr] = data;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic send(input logic [5:0] idx, input logic [57:0] mcn);
      mem_req_i_valid    = 1'b1;
      mem_req_i_bits_idx = idx;
      mem_req_i_bits_mcn = mcn;
      tick();
      mem_req_i_valid = 1'b0;
   endtask

   // Cycles counted from the cycle the request was presented; bounded so a stuck DUT still ends.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!mem_res_o_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      int lat;
      mem_res_o_ready = 1'b1;
      send(v.idx, v.mcn);
      wait_valid(lat);
      check_output("vec_latency", line_t'(lat), line_t'(v.exp_lat));
      check_output("vec_idx", line_t'(mem_res_o_bits_idx), line_t'(v.idx));
      check_output("vec_data", mem_res_o_bits_data, v.exp_data);
      tick();
      check_output("vec_drained", line_t'({mem_res_o_valid, busy_o}), line_t'(2'b00));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t  vecs [6];
      int    lat;
      logic [5:0]  exp_idx_q  [$];
      line_t       exp_data_q [$];
      logic [57:0] mcn_pool [5];

      reset = 1'b0;
      mem_req_i_valid = 1'b0;
      mem_req_i_bits_idx = '0;
      mem_req_i_bits_mcn = '0;
      mem_res_o_ready = 1'b0;
      ld_valid = 1'b0;
      ld_addr = '0;
      ld_data = '0;

      tick();
      tick();
      check_output("rst_ready", line_t'(mem_req_i_ready), line_t'(1'b0));
      check_output("rst_valid", line_t'(mem_res_o_valid), line_t'(1'b0));
      check_output("rst_busy", line_t'(busy_o), line_t'(1'b0));
      reset = 1'b1;
      #1;
      check_output("rel_ready", line_t'(mem_req_i_ready), line_t'(1'b1));
      tick();

      load(8'h00, pat(32'h0000_1111));
      load(8'h12, pat(32'hA5A5_A5A5));
      load(8'h7F, pat(32'h7F7F_0001));
      load(8'hFF, pat(32'hDEAD_BEEF));
      load(8'h05, pat(32'h0505_0505));

      vecs[0] = '{6'd3,  58'h12,  pat(32'hA5A5_A5A5), 4};
      vecs[1] = '{6'h3F, 58'hFF,  pat(32'hDEAD_BEEF), 4};
      vecs[2] = '{6'd5,  58'h100, '0,                 4};
      vecs[3] = '{6'd0,  58'h7F,  pat(32'h7F7F_0001), 4};
      vecs[4] = '{6'd9,  {1'b1, 57'h12}, '0,          4};
      vecs[5] = '{6'h2A, 58'h00,  pat(32'h0000_1111), 4};
      for (int v = 0; v < 6; v++) begin
         apply_stimulus(vecs[v]);
      end

      // Fill the queue with the consumer stalled, then show a same-cycle pop does not admit a push.
      mem_res_o_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mem_req_i_valid    = 1'b1;
         mem_req_i_bits_idx = 6'(i);
         mem_req_i_bits_mcn = 58'h100;
         check_output("fill_ready", line_t'(mem_req_i_ready), line_t'(1'b1));
         tick();
      end
      mem_req_i_bits_idx = 6'h2A;
      mem_req_i_bits_mcn = 58'h12;
      for (int c = 0; c < 3; c++) begin
         check_output("full_ready", line_t'(mem_req_i_ready), line_t'(1'b0));
         check_output("full_head", line_t'({mem_res_o_valid, mem_res_o_bits_idx}), line_t'(7'b1_000000));
         tick();
      end
      check_output("full_busy", line_t'(busy_o), line_t'(1'b1));
      mem_res_o_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         check_output("drain_valid", line_t'(mem_res_o_valid), line_t'(1'b1));
         check_output("drain_idx", line_t'(mem_res_o_bits_idx), line_t'((k < 8) ? 6'(k) : 6'h2A));
         if (k == 0) check_output("pop_full_ready", line_t'(mem_req_i_ready), line_t'(1'b0));
         if (k == 1) check_output("reopen_ready", line_t'(mem_req_i_ready), line_t'(1'b1));
         if (k == 8) check_output("late_data", mem_res_o_bits_data, pat(32'hA5A5_A5A5));
         tick();
         if (k == 1) mem_req_i_valid = 1'b0;
      end
      check_output("fill_drained", line_t'({mem_res_o_valid, busy_o}), line_t'(2'b00));

      // Table writes racing a response to the same line.
      mem_res_o_ready = 1'b0;
      send(6'd7, 58'h05);
      wait_valid(lat);
      check_output("wr_first_data", mem_res_o_bits_data, pat(32'h0505_0505));
      ld_valid = 1'b1;
      ld_addr  = 8'h05;
      ld_data  = pat(32'h5A5A_0001);
      tbl_model[8'h05] = ld_data;
      tick();
      ld_valid = 1'b0;
      check_output("wr_hold_valid", line_t'(mem_res_o_valid), line_t'(1'b1));
      check_output("wr_hold_data", mem_res_o_bits_data, pat(32'h0505_0505));
      mem_res_o_ready = 1'b1;
      tick();
      send(6'd8, 58'h05);
      wait_valid(lat);
      ld_valid = 1'b1;
      ld_addr  = 8'h05;
      ld_data  = pat(32'h5A5A_0002);
      tbl_model[8'h05] = ld_data;
      #1;
      check_output("wr_same_cycle", mem_res_o_bits_data, pat(32'h5A5A_0001));
      tick();
      ld_valid = 1'b0;
      send(6'd9, 58'h05);
      wait_valid(lat);
      check_output("wr_new_idx", line_t'(mem_res_o_bits_idx), line_t'(6'd9));
      check_output("wr_new_data", mem_res_o_bits_data, pat(32'h5A5A_0002));
      tick();

      // Streamed requests against a randomly stalling consumer, checked against a scoreboard.
      mcn_pool[0] = 58'h00;
      mcn_pool[1] = 58'h12;
      mcn_pool[2] = 58'h7F;
      mcn_pool[3] = 58'hFF;
      mcn_pool[4] = 58'h100;
      begin
         int    sent = 0;
         int    got = 0;
         int    cyc = 0;
         logic  prev_hold = 1'b0;
         logic [5:0] prev_idx = '0;
         line_t prev_data = '0;
         logic [57:0] mcn;
         while (got < 1000 && cyc < 20000) begin
            if (prev_hold) begin
               check_output("stall_stable",
                            {mem_res_o_valid, mem_res_o_bits_idx, mem_res_o_bits_data[504:0]},
                            {1'b1, prev_idx, prev_data[504:0]});
            end
            mem_res_o_ready = 1'($urandom_range(0, 1));
            if (mem_res_o_valid && mem_res_o_ready) begin
               if (exp_idx_q.size() == 0) begin
                  check_output("rand_unexpected", line_t'(mem_res_o_valid), line_t'(1'b0));
               end else begin
                  check_output("rand_idx", line_t'(mem_res_o_bits_idx), line_t'(exp_idx_q.pop_front()));
                  check_output("rand_data", mem_res_o_bits_data, exp_data_q.pop_front());
               end
               got++;
            end
            prev_hold = mem_res_o_valid && !mem_res_o_ready;
            prev_idx  = mem_res_o_bits_idx;
            prev_data = mem_res_o_bits_data;
            if (sent < 1000) begin
               mcn = mcn_pool[$urandom_range(0, 4)];
               mem_req_i_valid    = 1'b1;
               mem_req_i_bits_idx = 6'(sent);
               mem_req_i_bits_mcn = mcn;
               if (mem_req_i_ready) begin
                  exp_idx_q.push_back(6'(sent));
                  exp_data_q.push_back((mcn > 58'hFF) ? line_t'(0) : tbl_model[mcn[7:0]]);
                  sent++;
               end
            end else begin
               mem_req_i_valid = 1'b0;
            end
            tick();
            cyc++;
         end
         mem_req_i_valid = 1'b0;
         check_output("rand_count", line_t'(got), line_t'(1000));
      end
      mem_res_o_ready = 1'b1;
      tick();
      tick();

      // Reset while responses are queued: they must vanish, the table must survive.
      mem_res_o_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(6'(20 + i), 58'h12);
      end
      tick();
      tick();
      tick();
      check_output("pre_rst_valid", line_t'(mem_res_o_valid), line_t'(1'b1));
      reset = 1'b0;
      #1;
      check_output("mid_rst_valid", line_t'(mem_res_o_valid), line_t'(1'b0));
      check_output("mid_rst_busy", line_t'(busy_o), line_t'(1'b0));
      check_output("mid_rst_ready", line_t'(mem_req_i_ready), line_t'(1'b0));
      tick();
      reset = 1'b1;
      mem_res_o_ready = 1'b1;
      send(6'h11, 58'h12);
      wait_valid(lat);
      check_output("post_rst_latency", line_t'(lat), line_t'(4));
      check_output("post_rst_idx", line_t'(mem_res_o_bits_idx), line_t'(6'h11));
      check_output("post_rst_data", mem_res_o_bits_data, pat(32'hA5A5_A5A5));
      tick();
      check_output("post_rst_drained", line_t'({mem_res_o_valid, busy_o}), line_t'(2'b00));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
